mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage register, successor to the fixed 32-bit MEM/WB latch. It carries memory read data, ALU result, instruction word and a generalised control bundle from MEM to WB. Stages are coupled by a valid/ready handshake with an optional 2-entry skid buffer, and the block supports synchronous flush. It also exports a WB forwarding port: destination register, write-back value and enable, for the hazard/forwarding unit.

## Interface

Parameters:
- XLEN, 32, datapath width of mem data / ALU result / forward value
- IW, 32, instruction word width (must be ≥ 16)
- CTRL_W, 2, control bundle width (≥ 2); bit0 = RegWrite, bit1 = MemToReg, upper bits passed through
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; invalidates all held entries and drops any same-cycle input
- in_valid  in  1  MEM-side entry valid
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- dataMemIn  in  XLEN  memory read data
- ALUResultIn  in  XLEN  ALU result
- instrIn  in  IW  instruction word
- ctrlIn  in  CTRL_W  control bundle
- out_valid  out  1  WB-side entry valid
- out_ready  in  1  WB accepts; transfer when out_valid & out_ready
- dataMemOut  out  XLEN  held memory data
- ALUResultOut  out  XLEN  held ALU result
- instrOut  out  IW  held instruction
- ctrlOut  out  CTRL_W  held control
- fwd_en  out  1  out_valid & ctrlOut[0] & (fwd_rd != 0)
- fwd_rd  out  5  destination register: instrOut[15:11] if instrOut[31:26]==0, else instrOut[20:16]
- fwd_value  out  XLEN  ctrlOut[1] ? dataMemOut : ALUResultOut

## Operation

- Payload = {dataMem, ALUResult, instr, ctrl}. Main register drives the outputs; the skid register exists only when SKID=1.
- SKID=1 state machine:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- Transitions, with acc = in_valid & in_ready and fire = out_valid & out_ready:
  - EMPTY: acc → main ← in, FULL; else stay.
  - FULL: acc & fire → main ← in, stay FULL. acc & !fire → skid ← in, SKID. !acc & fire → EMPTY.
  - SKID: fire → main ← skid, FULL; in_ready = 0, so no acceptance.
- in_ready (SKID=1) = registered, 1 in EMPTY/FULL, 0 in SKID.
- SKID=0: one register; in_ready = !out_valid | out_ready (combinational); acc loads main; fire & !acc clears valid.
- Payload registers load only on acceptance or skid promotion; they hold otherwise (no bubble garbage).
- flush: next state EMPTY, both valids 0, in_ready 1; payload regs may hold stale data. Flush beats acc and fire in the same cycle.
- Forward outputs are combinational from held outputs only, never from inputs.
- Write to register 0 never forwards.

## Timing

- Reset values: out_valid 0, in_ready 1 (SKID=1) / 1 via comb (SKID=0), all payload outputs 0, fwd_en 0, fwd_rd 0, fwd_value 0, state EMPTY.
- Latency: accepted entry appears on outputs 1 cycle after the acceptance edge.
- Throughput: 1 entry/cycle while out_ready = 1.
- Backpressure (SKID=1): with out_ready low, a 2nd entry is accepted, then in_ready drops the following cycle. The 3rd entry is never lost.
- in_ready rises the cycle after the SKID-state fire.
- Ordering strictly FIFO; no entry duplicated or dropped except by flush.
- Reset asserted mid-transfer: all state cleared immediately (asynchronous). The first acceptance is possible on the first clk edge after deassertion.

## Test plan

- Reset then stream (SKID=1): instr 0x012A4020 (R-type, rd=8), ALU=0x5, ctrl=01, out_ready=1 → next cycle out_valid=1, fwd_rd=8, fwd_en=1, fwd_value=0x5.
- Load forward: instr 0x8C090004 (lw, rt=9), dataMem=0xDEADBEEF, ctrl=11 → fwd_rd=9, fwd_value=0xDEADBEEF; rd=0 variant → fwd_en=0.
- Backpressure: out_ready=0, present A, B, C on consecutive cycles → A held, B in skid, in_ready=0, C held by source. Release out_ready → A, B, C emerge in order on 3 successive cycles, no loss.
- Flush in SKID state with in_valid=1 → next cycle out_valid=0, in_ready=1, no entry emerges; following new entry passes normally.
- Async reset pulse between clock edges while FULL → out_valid and outputs 0 immediately, before the next edge.
- SKID=0 build: out_ready=0 with entry held → in_ready=0 combinationally; raising out_ready same cycle → in_ready=1 and replacement accepted that edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a write-back forwarding port for the hazard unit.
module mem_wb_stage #(
  parameter int XLEN   = 32,
  parameter int IW     = 32,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   dataMemIn,
  input  logic [XLEN-1:0]   ALUResultIn,
  input  logic [IW-1:0]     instrIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   dataMemOut,
  output logic [XLEN-1:0]   ALUResultOut,
  output logic [IW-1:0]     instrOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic              fwd_en,
  output logic [4:0]        fwd_rd,
  output logic [XLEN-1:0]   fwd_value
);

  localparam int PW = 2 * XLEN + IW + CTRL_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_reg;
  logic          acc;
  logic          fire;

  assign in_payload = {dataMemIn, ALUResultIn, instrIn, ctrlIn};
  assign {dataMemOut, ALUResultOut, instrOut, ctrlOut} = main_reg;
  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t        state_reg;
      state_t        state_next;
      logic [PW-1:0] skid_reg;
      logic          in_ready_reg;
      logic          load_main_in;
      logic          load_main_skid;
      logic          load_skid;

      always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
          ST_EMPTY: begin
            if (acc) begin
              load_main_in = 1'b1;
              state_next   = ST_FULL;
            end
          end
          ST_FULL: begin
            if (acc && fire) begin
              load_main_in = 1'b1;
            end else if (acc) begin
              load_skid  = 1'b1;
              state_next = ST_SKID;
            end else if (fire) begin
              state_next = ST_EMPTY;
            end
          end
          ST_SKID: begin
            // in_ready is low here, so only promotion of the skid entry can happen
            if (fire) begin
              load_main_skid = 1'b1;
              state_next     = ST_FULL;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
          state_next     = ST_EMPTY;
          load_main_in   = 1'b0;
          load_main_skid = 1'b0;
          load_skid      = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg    <= ST_EMPTY;
          in_ready_reg <= 1'b1;
          main_reg     <= '0;
          skid_reg     <= '0;
        end else begin
          state_reg    <= state_next;
          in_ready_reg <= (state_next != ST_SKID);
          if (load_main_in) begin
            main_reg <= in_payload;
          end else if (load_main_skid) begin
            main_reg <= skid_reg;
          end
          if (load_skid) begin
            skid_reg <= in_payload;
          end
        end
      end

      assign in_ready  = in_ready_reg;
      assign out_valid = (state_reg != ST_EMPTY);
    end else begin : g_single
      logic valid_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          main_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (acc) begin
          valid_reg <= 1'b1;
          main_reg  <= in_payload;
        end else if (fire) begin
          valid_reg <= 1'b0;
        end
      end

      assign in_ready  = ~valid_reg | out_ready;
      assign out_valid = valid_reg;
    end
  endgenerate

  // Opcode and rt fields, zero-extended when the instruction word is narrower than 32 bits
  logic [5:0] opcode;
  logic [4:0] rt_field;

  generate
    if (IW >= 32) begin : g_op_full
      assign opcode = instrOut[31:26];
    end else if (IW > 26) begin : g_op_part
      assign opcode = {{(32 - IW){1'b0}}, instrOut[IW-1:26]};
    end else begin : g_op_none
      assign opcode = '0;
    end

    if (IW >= 21) begin : g_rt_full
      assign rt_field = instrOut[20:16];
    end else if (IW > 16) begin : g_rt_part
      assign rt_field = {{(21 - IW){1'b0}}, instrOut[IW-1:16]};
    end else begin : g_rt_none
      assign rt_field = '0;
    end
  endgenerate

  assign fwd_rd    = (opcode == 6'd0) ? instrOut[15:11] : rt_field;
  assign fwd_value = ctrlOut[1] ? dataMemOut : ALUResultOut;
  assign fwd_en    = out_valid & ctrlOut[0] & (fwd_rd != 5'd0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected entries, a negedge monitor
// pops and compares whenever the WB side takes an entry. A second instance covers SKID=0.
module tb_mem_wb_stage;

  typedef struct {
    logic [31:0] data;
    logic [31:0] alu;
    logic [31:0] instr;
    logic [1:0]  ctrl;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] val;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dataMemIn;
  logic [31:0] ALUResultIn;
  logic [31:0] instrIn;
  logic [1:0]  ctrlIn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dataMemOut;
  logic [31:0] ALUResultOut;
  logic [31:0] instrOut;
  logic [1:0]  ctrlOut;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_value;

  logic        s0_flush;
  logic        s0_in_valid;
  logic        s0_in_ready;
  logic [31:0] s0_dataMemIn;
  logic [31:0] s0_ALUResultIn;
  logic [31:0] s0_instrIn;
  logic [1:0]  s0_ctrlIn;
  logic        s0_out_valid;
  logic        s0_out_ready;
  logic [31:0] s0_dataMemOut;
  logic [31:0] s0_ALUResultOut;
  logic [31:0] s0_instrOut;
  logic [1:0]  s0_ctrlOut;
  logic        s0_fwd_en;
  logic [4:0]  s0_fwd_rd;
  logic [31:0] s0_fwd_value;

  int    checks = 0;
  int    errors = 0;
  item_t sb[$];
  item_t mon_e;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .IW(32), .CTRL_W(2), .SKID(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dataMemIn(dataMemIn), .ALUResultIn(ALUResultIn), .instrIn(instrIn), .ctrlIn(ctrlIn),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataMemOut(dataMemOut), .ALUResultOut(ALUResultOut), .instrOut(instrOut), .ctrlOut(ctrlOut),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_value(fwd_value)
  );

  mem_wb_stage #(.XLEN(32), .IW(32), .CTRL_W(2), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .dataMemIn(s0_dataMemIn), .ALUResultIn(s0_ALUResultIn), .instrIn(s0_instrIn), .ctrlIn(s0_ctrlIn),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .dataMemOut(s0_dataMemOut), .ALUResultOut(s0_ALUResultOut), .instrOut(s0_instrOut),
    .ctrlOut(s0_ctrlOut),
    .fwd_en(s0_fwd_en), .fwd_rd(s0_fwd_rd), .fwd_value(s0_fwd_value)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [31:0] data, input logic [31:0] alu,
                               input logic [31:0] instr, input logic [1:0] ctrl,
                               input logic en, input logic [4:0] rd, input logic [31:0] val);
    item_t it;
    it.data = data; it.alu = alu; it.instr = instr; it.ctrl = ctrl;
    it.en = en; it.rd = rd; it.val = val;
    return it;
  endfunction

  task automatic drive(input item_t it);
    dataMemIn   = it.data;
    ALUResultIn = it.alu;
    instrIn     = it.instr;
    ctrlIn      = it.ctrl;
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input item_t it);
    int n;
    n = 0;
    drive(it);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready %b exp 1 instr %h", in_ready, it.instr);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(it);
    $display("send instr=%h alu=%h data=%h ctrl=%b", it.instr, it.alu, it.data, it.ctrl);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got instr %h exp none", instrOut);
      end else begin
        mon_e = sb.pop_front();
        $display("recv instr=%h alu=%h data=%h fwd_en=%b fwd_rd=%0d fwd_value=%h",
                 instrOut, ALUResultOut, dataMemOut, fwd_en, fwd_rd, fwd_value);
        check("mon_instr", {32'd0, instrOut}, {32'd0, mon_e.instr});
        check("mon_alu", {32'd0, ALUResultOut}, {32'd0, mon_e.alu});
        check("mon_data", {32'd0, dataMemOut}, {32'd0, mon_e.data});
        check("mon_ctrl", {62'd0, ctrlOut}, {62'd0, mon_e.ctrl});
        check("mon_fwd_en", {63'd0, fwd_en}, {63'd0, mon_e.en});
        check("mon_fwd_rd", {59'd0, fwd_rd}, {59'd0, mon_e.rd});
        check("mon_fwd_value", {32'd0, fwd_value}, {32'd0, mon_e.val});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    item_t v1, v2, v3, ia, ib, ic, id;
    v1 = mk(32'h0, 32'h5, 32'h012A4020, 2'b01, 1'b1, 5'd8, 32'h5);
    v2 = mk(32'hDEADBEEF, 32'h1000, 32'h8C090004, 2'b11, 1'b1, 5'd9, 32'hDEADBEEF);
    v3 = mk(32'hDEADBEEF, 32'h2000, 32'h8C000004, 2'b11, 1'b0, 5'd0, 32'hDEADBEEF);
    ia = mk(32'h11111111, 32'hA, 32'h00221820, 2'b01, 1'b1, 5'd3, 32'hA);
    ib = mk(32'h22222222, 32'hB, 32'h00A62020, 2'b01, 1'b1, 5'd4, 32'hB);
    ic = mk(32'hC0C0C0C0, 32'hC, 32'h8C0A0008, 2'b11, 1'b1, 5'd10, 32'hC0C0C0C0);
    id = mk(32'h33333333, 32'h77, 32'h00221820, 2'b00, 1'b0, 5'd3, 32'h77);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0));
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_dataMemIn = 32'h0; s0_ALUResultIn = 32'h0; s0_instrIn = 32'h0; s0_ctrlIn = 2'b00;

    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_alu", {32'd0, ALUResultOut}, 64'd0);
    check("rst_instr", {32'd0, instrOut}, 64'd0);
    check("rst_data", {32'd0, dataMemOut}, 64'd0);
    check("rst_fwd_en", {63'd0, fwd_en}, 64'd0);
    check("rst_fwd_rd", {59'd0, fwd_rd}, 64'd0);
    check("rst_fwd_value", {32'd0, fwd_value}, 64'd0);
    check("rst_s0_in_ready", {63'd0, s0_in_ready}, 64'd1);
    check("rst_s0_out_valid", {63'd0, s0_out_valid}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming with out_ready high: one entry per cycle, one-cycle latency
    send(v1);
    check("lat_out_valid", {63'd0, out_valid}, 64'd1);
    check("lat_fwd_rd", {59'd0, fwd_rd}, 64'd8);
    check("lat_fwd_en", {63'd0, fwd_en}, 64'd1);
    check("lat_fwd_value", {32'd0, fwd_value}, 64'h5);
    send(v2);
    send(v3);
    repeat (3) @(posedge clk);
    #1;
    check("stream_drain", 64'(sb.size()), 64'd0);

    // Backpressure: A held, B in skid, C waits at the source
    out_ready = 1'b0;
    send(ia);
    send(ib);
    fork
      send(ic);
      begin
        @(negedge clk);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_instr", {32'd0, instrOut}, {32'd0, ia.instr});
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_drain", 64'(sb.size()), 64'd0);

    // Flush while in the skid state with an input pending
    out_ready = 1'b0;
    send(ia);
    send(ib);
    drive(ic);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(id);
    repeat (3) @(posedge clk);
    #1;
    check("flush_drain", 64'(sb.size()), 64'd0);

    // Flush beats a same-cycle acceptance while FULL
    out_ready = 1'b0;
    send(v1);
    drive(v2);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("ffl_out_valid", {63'd0, out_valid}, 64'd0);
    check("ffl_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ffl_no_emerge", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges while FULL, then first acceptance after release
    out_ready = 1'b0;
    send(v1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check("ar_alu", {32'd0, ALUResultOut}, 64'd0);
    check("ar_instr", {32'd0, instrOut}, 64'd0);
    check("ar_fwd_en", {63'd0, fwd_en}, 64'd0);
    check("ar_fwd_value", {32'd0, fwd_value}, 64'd0);
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    drive(v2);
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    sb.push_back(v2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ar_first_acc_valid", {63'd0, out_valid}, 64'd1);
    check("ar_first_acc_instr", {32'd0, instrOut}, {32'd0, v2.instr});
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ar_drain", 64'(sb.size()), 64'd0);

    // SKID=0 build: combinational in_ready follows out_ready
    s0_out_ready = 1'b0;
    s0_dataMemIn = v1.data; s0_ALUResultIn = v1.alu; s0_instrIn = v1.instr; s0_ctrlIn = v1.ctrl;
    s0_in_valid = 1'b1;
    @(posedge clk); #1;
    check("s0_out_valid", {63'd0, s0_out_valid}, 64'd1);
    check("s0_alu_e1", {32'd0, s0_ALUResultOut}, 64'h5);
    check("s0_in_ready_low", {63'd0, s0_in_ready}, 64'd0);
    s0_dataMemIn = id.data; s0_ALUResultIn = id.alu; s0_instrIn = id.instr; s0_ctrlIn = id.ctrl;
    s0_out_ready = 1'b1;
    #1;
    check("s0_in_ready_comb", {63'd0, s0_in_ready}, 64'd1);
    @(posedge clk); #1;
    $display("s0 recv instr=%h alu=%h fwd_en=%b fwd_rd=%0d", s0_instrOut, s0_ALUResultOut,
             s0_fwd_en, s0_fwd_rd);
    check("s0_repl_valid", {63'd0, s0_out_valid}, 64'd1);
    check("s0_repl_alu", {32'd0, s0_ALUResultOut}, 64'h77);
    check("s0_repl_fwd_rd", {59'd0, s0_fwd_rd}, 64'd3);
    check("s0_repl_fwd_en", {63'd0, s0_fwd_en}, 64'd0);
    check("s0_repl_fwd_value", {32'd0, s0_fwd_value}, 64'h77);
    s0_in_valid = 1'b0;
    @(posedge clk); #1;
    check("s0_empty", {63'd0, s0_out_valid}, 64'd0);

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
